// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, FSM encoding and the reset baud divisor.
package uart_pkg;

   localparam logic [1:0] OFF_TXDATA  = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_DIVISOR = 2'd2;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_OVERRUN = 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   // 115200 baud from a 50 MHz clock: 434 clocks per bit
   localparam logic [15:0] UART_DEFAULT_DIV = 16'd433;

   typedef struct packed {
      logic [1:0] state;
      logic [2:0] bit_idx;
      logic       full;
      logic       overrun;
   } uart_dbg_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts DIVISOR..0 and flags the last clock of each bit.
// The count reloads from the live divisor at every bit boundary.
module uart_baud_gen
   import uart_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        restart,
   input  logic [15:0] divisor,
   output logic        bit_done
);

   logic [15:0] cnt;

   assign bit_done = (cnt == 16'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (restart || bit_done) begin
         cnt <= divisor;
      end else begin
         cnt <= cnt - 16'd1;
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a one-byte holding register,
// sticky overrun flag and programmable bit period.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter int          DATA_WIDTH  = 32,
   parameter logic [15:0] DEFAULT_DIV = UART_DEFAULT_DIV
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Select_i,
   input  logic [31:0]           Address_i,
   input  logic [DATA_WIDTH-1:0] WriteData_i,
   input  logic                  MemWrite_i,
   output logic [DATA_WIDTH-1:0] ReadData_o,
   output logic                  tx_o
);

   // Bus handshake: a cycle with Select_i=1 is a transfer that is always accepted
   // (no wait states); writes commit at that rising edge, reads are combinational.
   logic        wr_tx, wr_status, wr_div;
   logic [1:0]  state;
   logic [2:0]  bit_idx;
   logic [7:0]  shifter, holding;
   logic        full, overrun, busy;
   logic [15:0] divisor;
   logic        bit_done, restart, frame_end;
   uart_dbg_t   dbg;
   logic        unused_bits;

   assign wr_tx     = Select_i && MemWrite_i && (Address_i[3:2] == OFF_TXDATA);
   assign wr_status = Select_i && MemWrite_i && (Address_i[3:2] == OFF_STATUS);
   assign wr_div    = Select_i && MemWrite_i && (Address_i[3:2] == OFF_DIVISOR);
   assign busy      = (state != S_IDLE) || full;
   assign restart   = (state == S_IDLE) && wr_tx;
   assign frame_end = (state == S_STOP) && bit_done;
   assign dbg       = {state, bit_idx, full, overrun};
   assign unused_bits = ^{Address_i[31:4], Address_i[1:0], WriteData_i[DATA_WIDTH-1:16], dbg};

   uart_baud_gen u_baud (
      .clk      (clk),
      .reset    (reset),
      .restart  (restart),
      .divisor  (divisor),
      .bit_done (bit_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         tx_o    <= 1'b1;
         shifter <= '0;
         bit_idx <= '0;
         holding <= '0;
         full    <= 1'b0;
         overrun <= 1'b0;
         divisor <= DEFAULT_DIV;
      end else begin
         if (wr_div) divisor <= WriteData_i[15:0];

         // a write that finds the holding register full is dropped; set beats clear
         if (wr_tx && full) begin
            overrun <= 1'b1;
         end else if (wr_status && WriteData_i[STAT_OVERRUN]) begin
            overrun <= 1'b0;
         end

         // at the stop-bit boundary an incoming byte goes straight to the shifter
         if (wr_tx && !full && (state != S_IDLE) && !frame_end) begin
            holding <= WriteData_i[7:0];
            full    <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (wr_tx && !full) begin
                  shifter <= WriteData_i[7:0];
                  tx_o    <= 1'b0;
                  state   <= S_START;
               end
            end
            S_START: begin
               if (bit_done) begin
                  tx_o    <= shifter[0];
                  shifter <= {1'b0, shifter[7:1]};
                  bit_idx <= 3'd0;
                  state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (bit_done) begin
                  if (bit_idx == 3'd7) begin
                     tx_o  <= 1'b1;
                     state <= S_STOP;
                  end else begin
                     tx_o    <= shifter[0];
                     shifter <= {1'b0, shifter[7:1]};
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            S_STOP: begin
               if (bit_done) begin
                  if (full) begin
                     shifter <= holding;
                     full    <= 1'b0;
                     tx_o    <= 1'b0;
                     state   <= S_START;
                  end else if (wr_tx) begin
                     shifter <= WriteData_i[7:0];
                     tx_o    <= 1'b0;
                     state   <= S_START;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      ReadData_o = '0;
      if (Select_i) begin
         case (Address_i[3:2])
            OFF_STATUS: begin
               ReadData_o[STAT_BUSY]    = busy;
               ReadData_o[STAT_FULL]    = full;
               ReadData_o[STAT_OVERRUN] = overrun;
            end
            OFF_DIVISOR: ReadData_o[15:0] = divisor;
            default: ReadData_o = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: frame-level reference model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_uart_tx_mmio;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel, we;
   logic [31:0] addr, wdata, rdata;
   logic        tx;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   uart_tx_mmio dut (
      .clk         (clk),
      .reset       (reset),
      .Select_i    (sel),
      .Address_i   (addr),
      .WriteData_i (wdata),
      .MemWrite_i  (we),
      .ReadData_o  (rdata),
      .tx_o        (tx)
   );

   // ---------------- reference model ----------------
   // A frame is the 10-bit pattern {stop, data, start}; m_pos is the bit on the
   // line and m_rem the clocks left in it, each bit lasting divisor+1 clocks.
   bit          m_active, m_hv, m_ovr;
   int          m_pos, m_rem;
   logic [9:0]  m_frame;
   logic [7:0]  m_hd;
   logic [15:0] m_div;

   task automatic model_reset();
      m_active = 0; m_hv = 0; m_ovr = 0; m_pos = 0; m_rem = 0;
      m_frame = '1; m_hd = '0; m_div = 16'd433;
   endtask

   task automatic model_start(input logic [7:0] b, input logic [15:0] d);
      m_active = 1; m_pos = 0; m_rem = int'(d) + 1;
      m_frame = {1'b1, b, 1'b0};
   endtask

   task automatic model_step();
      bit wr_tx, wr_st, wr_dv, pre_hv, pre_act, frame_end, consumed, ovr_set;
      logic [15:0] d;
      wr_tx = sel && we && (addr[3:2] == 2'd0);
      wr_st = sel && we && (addr[3:2] == 2'd1);
      wr_dv = sel && we && (addr[3:2] == 2'd2);
      pre_hv = m_hv; pre_act = m_active; d = m_div;
      frame_end = 0; consumed = 0; ovr_set = 0;
      if (m_active) begin
         if (m_rem == 1) begin
            if (m_pos == 9) frame_end = 1;
            else begin m_pos++; m_rem = int'(d) + 1; end
         end else m_rem--;
      end
      if (frame_end) begin
         if (pre_hv) begin model_start(m_hd, d); m_hv = 0; end
         else if (wr_tx) begin model_start(wdata[7:0], d); consumed = 1; end
         else m_active = 0;
      end
      if (wr_tx && !consumed) begin
         if (pre_hv) ovr_set = 1;
         else if (!pre_act) model_start(wdata[7:0], d);
         else begin m_hv = 1; m_hd = wdata[7:0]; end
      end
      if (wr_st && wdata[2]) m_ovr = 0;
      if (ovr_set) m_ovr = 1;
      if (wr_dv) m_div = wdata[15:0];
   endtask

   function automatic logic model_tx();
      return m_active ? m_frame[m_pos] : 1'b1;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      case (a[3:2])
         2'd1:    return {29'd0, m_ovr, m_hv, (m_active || m_hv)};
         2'd2:    return {16'd0, m_div};
         default: return 32'd0;
      endcase
   endfunction

   initial forever begin
      @(posedge clk);
      if (!reset) model_step();
   end

   initial forever begin
      @(posedge reset);
      model_reset();
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (reset) check("tx_in_reset", {31'd0, tx}, 32'd1);
      else begin
         check("tx_vs_model", {31'd0, tx}, {31'd0, model_tx()});
         if (!sel) check("rdata_unselected", rdata, 32'd0);
         else if (!we) check("rdata_vs_model", rdata, model_read(addr));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic bus_idle();
      sel = 0; we = 0; addr = '0; wdata = '0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      sel = 1; we = 1; addr = {28'd0, a}; wdata = d;
      sync();
      sel = 0; we = 0;
   endtask

   task automatic rd_setup(input logic [3:0] a);
      sel = 1; we = 0; addr = {28'd0, a};
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      rd_setup(4'h4);
      @(negedge clk);
      while (rdata[0] && n < limit) begin @(negedge clk); n++; end
      check("idle_within_budget", {31'd0, (n < limit)}, 32'd1);
      sync();
      bus_idle();
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset_state();
      rd_setup(4'h4);
      @(negedge clk); check("reset_status", rdata, 32'd0);
      addr = 32'h8;
      @(negedge clk); check("reset_divisor", rdata, 32'd433);
      bus_idle();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); check("reset_tx_idle", {31'd0, tx}, 32'd1);
      end
      sync();
   endtask

   task automatic test_single_frame();
      logic [7:0] b;
      b = 8'h55;
      wr(4'h8, 32'd3);
      check("t2_tx_before_write", {31'd0, tx}, 32'd1);
      wr(4'h0, {24'd0, b});
      check("t2_tx_low_after_edge", {31'd0, tx}, 32'd0);
      for (int k = 0; k < 10; k++)
         for (int r = 0; r < 4; r++)
            exp_q.push_back((k == 0) ? 32'd0 : (k == 9) ? 32'd1 : 32'((b >> (k - 1)) & 8'h1));
      rd_setup(4'h4);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("t2_tx_bit", {31'd0, tx}, exp_q.pop_front());
         check("t2_busy", {31'd0, rdata[0]}, 32'd1);
      end
      @(negedge clk);
      check("t2_busy_end", {31'd0, rdata[0]}, 32'd0);
      check("t2_tx_idle", {31'd0, tx}, 32'd1);
      sync();
      bus_idle();
   endtask

   task automatic test_back_to_back();
      int  n;
      logic s[300];
      wr(4'h0, 32'hA5);
      wr(4'h0, 32'h3C);
      rd_setup(4'h4);
      @(negedge clk);
      check("t3_status_full", rdata, 32'd3);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         if (!rdata[0]) break;
         s[i] = tx;
         n++;
         @(negedge clk);
      end
      check("t3_busy_cycles", n, 32'd79);
      check("t3_first_stop", {31'd0, s[38]}, 32'd1);
      check("t3_second_start", {31'd0, s[39]}, 32'd0);
      sync();
      bus_idle();
   endtask

   task automatic test_overrun();
      wr(4'h0, 32'h01);
      wr(4'h0, 32'h02);
      wr(4'h0, 32'h03);
      rd_setup(4'h4);
      @(negedge clk); check("t4_status_overrun", rdata, 32'd7);
      sync();
      wr(4'h4, 32'h4);
      rd_setup(4'h4);
      @(negedge clk); check("t4_overrun_cleared", rdata, 32'd3);
      sync();
      wait_idle(200);
   endtask

   task automatic test_div_change();
      logic samples[$];
      int   runs[$];
      int   len;
      wr(4'h8, 32'd7);
      wr(4'h0, 32'h55);
      fork
         for (int i = 0; i < 56; i++) begin @(negedge clk); samples.push_back(tx); end
         begin repeat (26) sync(); wr(4'h8, 32'd1); end
      join
      len = 1;
      for (int i = 1; i < samples.size(); i++) begin
         if (samples[i] == samples[i-1]) len++;
         else begin runs.push_back(len); len = 1; end
      end
      runs.push_back(len);
      foreach (runs[i]) ;
      for (int k = 0; k < 9; k++) exp_q.push_back((k < 4) ? 32'd8 : 32'd2);
      for (int k = 0; k < 9; k++)
         check("t5_bit_run_length", (k < runs.size()) ? 32'(runs[k]) : 32'hFFFF_FFFF, exp_q.pop_front());
      sync();
      wait_idle(200);
   endtask

   task automatic test_reset_midframe();
      wr(4'h8, 32'd3);
      wr(4'h0, 32'h00);
      repeat (21) sync();
      check("t6_tx_low_in_bit4", {31'd0, tx}, 32'd0);
      reset = 1;
      #1;
      check("t6_tx_async_high", {31'd0, tx}, 32'd1);
      repeat (2) sync();
      reset = 0;
      rd_setup(4'h4);
      @(negedge clk); check("t6_status_after_reset", rdata, 32'd0);
      addr = 32'h8;
      @(negedge clk); check("t6_divisor_after_reset", rdata, 32'd433);
      sync();
      sel = 0; we = 1; addr = 32'h0; wdata = $urandom();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("t6_unselected_tx", {31'd0, tx}, 32'd1);
         check("t6_unselected_rdata", rdata, 32'd0);
      end
      sync();
      bus_idle();
   endtask

   task automatic random_traffic(input int n);
      int r;
      wr(4'h8, 32'd1);
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 99);
         sel = 1; we = 1;
         addr = $urandom() & 32'hFFFF_FFF3;
         wdata = $urandom();
         if (r < 6) addr = addr | 32'h0;
         else if (r < 9) addr = addr | 32'h4;
         else if (r < 11) begin
            addr = addr | 32'h8;
            wdata = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
         end
         else if (r < 12) addr = addr | 32'hC;
         else if (r < 20) begin sel = 0; addr = $urandom(); end
         else if (r < 60) begin we = 0; addr = $urandom(); end
         else begin sel = 0; we = 0; end
         sync();
      end
      bus_idle();
   endtask

   // ---------------- main sequence and report ----------------
   initial begin
      reset = 1;
      bus_idle();
      model_reset();
      repeat (3) sync();
      reset = 0;
      test_reset_state();
      test_single_frame();
      test_back_to_back();
      test_overrun();
      test_div_change();
      test_reset_midframe();
      random_traffic(3000);
      wait_idle(2000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation exceeded time budget at %0t", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
